// File: rtl/retry_pkg.sv
// Shared helpers for the retry start/end stages: ID parity check, ID increment
// with parity regeneration, slot count, and the routing enum.
package retry_pkg;

    typedef enum logic {
        ROUTE_OUT   = 1'b0,
        ROUTE_RETRY = 1'b1
    } route_e;

    // The MSB of an ID is the XOR of all lower bits; ids are passed zero-extended.
    function automatic logic id_parity_ok(input logic [31:0] id, input int id_size);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (i < id_size - 1) begin
                p = p ^ id[i];
            end
        end
        return p == id[id_size-1];
    endfunction

    function automatic logic [31:0] id_next(input logic [31:0] id, input int id_size);
        logic [31:0] mask;
        logic [31:0] low;
        logic        p;
        mask = (32'd1 << (id_size - 1)) - 32'd1;
        low  = (id + 32'd1) & mask;
        p    = ^low;
        return low | ({31'd0, p} << (id_size - 1));
    endfunction

    function automatic int slot_count(input int id_size);
        return 1 << (id_size - 1);
    endfunction

endpackage

// File: rtl/retry_out_buffer.sv
// Two-entry valid/ready FIFO; head entry is driven straight from a register.
// Accepts a push while full if the head is popped in the same cycle.
module retry_out_buffer #(
    parameter type EntryType = logic
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  EntryType push_data,
    input  logic     push_valid,
    output logic     push_ready,
    output EntryType pop_data,
    output logic     pop_valid,
    input  logic     pop_ready
);

    EntryType   slot0_reg;
    EntryType   slot1_reg;
    logic [1:0] count_reg;
    logic       push;
    logic       pop;

    assign pop_valid  = !rst_i && (count_reg != 2'd0);
    assign pop        = pop_valid && pop_ready;
    assign push_ready = !rst_i && ((count_reg != 2'd2) || pop);
    assign push       = push_valid && push_ready;
    assign pop_data   = slot0_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        slot0_reg <= push_data;
                    end else begin
                        slot1_reg <= push_data;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    slot0_reg <= slot1_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        slot0_reg <= push_data;
                    end else begin
                        slot0_reg <= slot1_reg;
                        slot1_reg <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/retry_end_buffered.sv
// End stage of the retry loop: routes results to a retry channel or a 2-entry
// output buffer. Optional statistics counters with RETRY_END_STATS_EN.
module retry_end_buffered
    import retry_pkg::*;
#(
    parameter type DataType   = logic,
    parameter int  IDSize     = 2,
    parameter int  MaxRetries = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              needs_retry_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic              error_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [IDSize-1:0] retry_id_o,
    output logic              retry_valid_o,
    input  logic              retry_ready_i,
    output logic              parity_error_o,
    output logic              retry_limit_o
`ifdef RETRY_END_STATS_EN
    ,
    output logic [31:0]       retry_count_o,
    output logic [31:0]       error_count_o
`endif
);

    localparam int CntW = $clog2(MaxRetries + 1);

    typedef struct packed {
        DataType data;
        logic    error;
    } entry_t;

    logic              par_ok;
    route_e            route;
    logic              out_error;
    logic              hit_limit;
    logic              accept;
    logic              buf_push_valid;
    logic              buf_push_ready;
    logic              buf_pop_valid;
    entry_t            buf_push_data;
    entry_t            buf_head;
    logic [CntW-1:0]   cnt_reg;
    logic              retry_valid_reg;
    logic [IDSize-1:0] retry_id_reg;
    logic              parity_error_reg;
    logic              retry_limit_reg;

    assign par_ok = id_parity_ok(32'(id_i), IDSize);

    // Parity failure outranks the retry verdict: a corrupted ID must never be replayed.
    always_comb begin
        route     = ROUTE_OUT;
        out_error = 1'b0;
        hit_limit = 1'b0;
        if (!par_ok) begin
            out_error = 1'b1;
        end else if (needs_retry_i && (cnt_reg == CntW'(MaxRetries))) begin
            out_error = 1'b1;
            hit_limit = 1'b1;
        end else if (needs_retry_i) begin
            route = ROUTE_RETRY;
        end
    end

    assign ready_o = !rst_i && ((route == ROUTE_RETRY) ? (!retry_valid_reg || retry_ready_i)
                                                       : buf_push_ready);
    assign accept  = valid_i && ready_o;

    assign buf_push_valid      = valid_i && !rst_i && (route == ROUTE_OUT);
    assign buf_push_data.data  = data_i;
    assign buf_push_data.error = out_error;

    retry_out_buffer #(
        .EntryType(entry_t)
    ) u_out_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_data (buf_push_data),
        .push_valid(buf_push_valid),
        .push_ready(buf_push_ready),
        .pop_data  (buf_head),
        .pop_valid (buf_pop_valid),
        .pop_ready (ready_i)
    );

    assign valid_o = buf_pop_valid;
    assign data_o  = buf_head.data;
    assign error_o = buf_pop_valid && buf_head.error;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_valid_reg  <= 1'b0;
            cnt_reg          <= '0;
            parity_error_reg <= 1'b0;
            retry_limit_reg  <= 1'b0;
        end else begin
            parity_error_reg <= accept && !par_ok;
            retry_limit_reg  <= accept && hit_limit;
            if (accept && (route == ROUTE_RETRY)) begin
                retry_valid_reg <= 1'b1;
                retry_id_reg    <= id_i;
                if (cnt_reg != CntW'(MaxRetries)) begin
                    cnt_reg <= cnt_reg + CntW'(1);
                end
            end else begin
                if (retry_ready_i) begin
                    retry_valid_reg <= 1'b0;
                end
                if (accept) begin
                    cnt_reg <= '0;
                end
            end
        end
    end

    assign retry_valid_o  = retry_valid_reg && !rst_i;
    assign retry_id_o     = retry_id_reg;
    assign parity_error_o = parity_error_reg && !rst_i;
    assign retry_limit_o  = retry_limit_reg && !rst_i;

`ifdef RETRY_END_STATS_EN
    logic [31:0] retry_count_reg;
    logic [31:0] error_count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_count_reg <= 32'd0;
            error_count_reg <= 32'd0;
        end else begin
            if (accept && (route == ROUTE_RETRY) && (retry_count_reg != 32'hFFFF_FFFF)) begin
                retry_count_reg <= retry_count_reg + 32'd1;
            end
            if (accept && out_error && (error_count_reg != 32'hFFFF_FFFF)) begin
                error_count_reg <= error_count_reg + 32'd1;
            end
        end
    end

    assign retry_count_o = retry_count_reg;
    assign error_count_o = error_count_reg;
`endif

endmodule

// File: tb/tb_retry_end_buffered.sv
// Bench for retry_end_buffered (IDSize=3, 8-bit data, MaxRetries=2): directed
// scenarios with literal expectations, then random traffic against a queue model.
module tb_retry_end_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic [2:0] id_i;
    logic       needs_retry_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       error_o;
    logic       valid_o;
    logic       ready_i;
    logic [2:0] retry_id_o;
    logic       retry_valid_o;
    logic       retry_ready_i;
    logic       parity_error_o;
    logic       retry_limit_o;

    always #5 clk = ~clk;

    retry_end_buffered #(
        .DataType  (logic [7:0]),
        .IDSize    (3),
        .MaxRetries(2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_i        (data_i),
        .id_i          (id_i),
        .needs_retry_i (needs_retry_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .error_o       (error_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .retry_id_o    (retry_id_o),
        .retry_valid_o (retry_valid_o),
        .retry_ready_i (retry_ready_i),
        .parity_error_o(parity_error_o),
        .retry_limit_o (retry_limit_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       e;
    } ent_t;

    // Model state: forwarded results in acceptance order, pending retry, consecutive retries.
    ent_t       q[$];
    bit         rpend;
    logic [2:0] rid;
    int         consec;
    bit         exp_perr;
    bit         exp_lim;
    int         checks = 0;
    int         passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input logic [2:0] id,
                         input bit n, input bit rdy, input bit rrdy);
        valid_i       = v;
        data_i        = d;
        id_i          = id;
        needs_retry_i = n;
        ready_i       = rdy;
        retry_ready_i = rrdy;
    endtask

    // Called just after a falling edge with inputs set; compares, then advances the model.
    task automatic step();
        bit par_ok, to_retry, err, lim_now, exp_ready, exp_valid, acc;
        #1;
        par_ok   = (id_i[2] == (id_i[1] ^ id_i[0]));
        err      = 1'b0;
        lim_now  = 1'b0;
        to_retry = 1'b0;
        if (!par_ok) err = 1'b1;
        else if (needs_retry_i && consec == 2) begin err = 1'b1; lim_now = 1'b1; end
        else if (needs_retry_i) to_retry = 1'b1;
        exp_valid = !rst && q.size() > 0;
        if (to_retry) exp_ready = !rst && (!rpend || retry_ready_i);
        else exp_ready = !rst && (q.size() < 2 || (exp_valid && ready_i));
        chk("ready_o", ready_o, exp_ready);
        chk("valid_o", valid_o, exp_valid);
        if (exp_valid) begin
            chk("data_o", data_o, q[0].d);
            chk("error_o", error_o, q[0].e);
        end
        chk("retry_valid_o", retry_valid_o, !rst && rpend);
        if (!rst && rpend) chk("retry_id_o", retry_id_o, rid);
        chk("parity_error_o", parity_error_o, !rst && exp_perr);
        chk("retry_limit_o", retry_limit_o, !rst && exp_lim);
        acc = valid_i && exp_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            rpend    = 1'b0;
            consec   = 0;
            exp_perr = 1'b0;
            exp_lim  = 1'b0;
        end else begin
            if (exp_valid && ready_i) void'(q.pop_front());
            if (rpend && retry_ready_i) rpend = 1'b0;
            exp_perr = acc && !par_ok;
            exp_lim  = acc && lim_now;
            if (acc) begin
                if (to_retry) begin
                    rpend = 1'b1;
                    rid   = id_i;
                    consec++;
                end else begin
                    q.push_back('{d: data_i, e: err});
                    consec = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit lim_rv[4];
        logic [2:0] rid_v;
        lim_rv   = '{1'b1, 1'b1, 1'b0, 1'b1};
        rpend    = 1'b0;
        rid      = 3'd0;
        consec   = 0;
        exp_perr = 1'b0;
        exp_lim  = 1'b0;
        rst      = 1'b1;
        drive(0, 8'h00, 3'b000, 0, 1, 0);
        @(negedge clk);
        #1 chk("rst_ready", ready_o, 0);
        step();
        step();
        rst = 1'b0;

        // Clean pass-through.
        drive(1, 8'hA1, 3'b101, 0, 1, 0);
        step();
        drive(0, 8'h00, 3'b000, 0, 1, 0);
        #1;
        chk("pass_valid", valid_o, 1);
        chk("pass_data", data_o, 8'hA1);
        chk("pass_err", error_o, 0);
        chk("pass_noretry", retry_valid_o, 0);
        step();

        // Retry held while start stage stalls; clean input still flows.
        drive(1, 8'h33, 3'b110, 1, 1, 0);
        step();
        drive(0, 8'h00, 3'b000, 0, 1, 0);
        repeat (3) begin
            #1;
            chk("hold_rv", retry_valid_o, 1);
            chk("hold_rid", retry_id_o, 3'b110);
            step();
        end
        drive(1, 8'h44, 3'b011, 1, 1, 0);
        #1 chk("hold_block", ready_o, 0);
        step();
        drive(1, 8'h5C, 3'b000, 0, 1, 0);
        #1 chk("hold_clean_rdy", ready_o, 1);
        step();
        drive(0, 8'h00, 3'b000, 0, 1, 1);
        #1 chk("hold_clean_fwd", data_o, 8'h5C);
        step();

        // Bad parity with needs_retry set.
        drive(1, 8'h66, 3'b001, 1, 1, 0);
        step();
        drive(0, 8'h00, 3'b000, 0, 1, 0);
        #1;
        chk("perr_pulse", parity_error_o, 1);
        chk("perr_err", error_o, 1);
        chk("perr_data", data_o, 8'h66);
        chk("perr_noretry", retry_valid_o, 0);
        step();
        #1 chk("perr_once", parity_error_o, 0);

        // Retry limit: 2 retries, third forced out, fourth retries again.
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'h70 + 8'(k), 3'b110, 1, 1, 1);
            step();
            chk("limit_rv", retry_valid_o, lim_rv[k]);
            if (k == 2) begin
                chk("limit_pulse", retry_limit_o, 1);
                chk("limit_err", error_o, 1);
                chk("limit_data", data_o, 8'h72);
            end
        end
        drive(0, 8'h00, 3'b000, 0, 1, 1);
        step();
        step();

        // Backpressure ordering.
        drive(1, 8'h11, 3'b000, 0, 0, 0);
        step();
        drive(1, 8'h22, 3'b000, 0, 0, 0);
        step();
        drive(1, 8'h33, 3'b000, 0, 0, 0);
        #1 chk("bp_block", ready_o, 0);
        step();
        drive(0, 8'h00, 3'b000, 0, 1, 0);
        #1 chk("bp_first", data_o, 8'h11);
        step();
        #1 chk("bp_second", data_o, 8'h22);
        step();
        #1 chk("bp_empty", valid_o, 0);

        // Reset while holding two results and a pending retry.
        drive(1, 8'hB1, 3'b000, 0, 0, 0);
        step();
        drive(1, 8'hB2, 3'b000, 0, 0, 0);
        step();
        drive(1, 8'hB3, 3'b110, 1, 0, 0);
        step();
        rst = 1'b1;
        drive(0, 8'h00, 3'b000, 0, 0, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_retry", retry_valid_o, 0);
        chk("rst_ready1", ready_o, 1);
        step();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(99) == 0);
            rid_v = 3'($urandom_range(7));
            if ($urandom_range(3) != 0) rid_v[2] = rid_v[1] ^ rid_v[0];
            drive($urandom_range(9) < 7, 8'($urandom_range(255)), rid_v,
                  $urandom_range(2) == 0, $urandom_range(9) < 6, $urandom_range(1) == 1);
            step();
        end
        rst = 1'b0;
        drive(0, 8'h00, 3'b000, 0, 1, 1);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
